// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the IF/DM arbiter: one request channel toward the
// unified instruction/data memory and its acknowledge/read-data return.
interface mem_port_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // The arbiter drives the request side of the bus.
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    // The backing memory answers on the acknowledge side.
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the fetch stage (IF, word reads) and
// the memory stage (DM, byte/word loads and stores). One transaction at a
// time moves through IDLE -> ISSUE -> RESP. DM has priority, except that IF
// is forced through after STARVE_MAX consecutive DM grants made while IF was
// waiting. A memory cycle that is not acknowledged within TIMEOUT cycles
// completes with err=1 and zero read data.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,   // 1..15
    parameter int TIMEOUT    = 16   // 1..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        err,
    output logic [1:0]  owner,
    mem_port_arbiter_if.master mem
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_IF = 2'b01, OWN_DM = 2'b10} owner_t;

    localparam logic [3:0] STARVE_W  = 4'(STARVE_MAX);
    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    state_t      state_q, state_d;
    owner_t      owner_q;
    logic [3:0]  starve_q;
    logic [7:0]  tmo_q;

    // Request fields latched at grant; requester inputs are free after that.
    logic        lat_we;
    logic        lat_byte_load;
    logic [1:0]  lat_lane;
    logic [31:0] lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic [31:0] rdata_q;
    logic        err_q;

    // Arbitration and completion conditions evaluated in the current cycle.
    logic        force_if;
    logic        pick_dm;
    logic        pick_if;
    logic        if_misaligned;
    logic        dm_misaligned;
    logic        req_misaligned;
    logic        timed_out;
    logic [7:0]  lane_byte;

    assign force_if       = if_req && (starve_q >= STARVE_W);
    assign pick_dm        = dm_req && !force_if;
    assign pick_if        = if_req && !pick_dm;
    assign if_misaligned  = (if_addr[1:0] != 2'b00);
    assign dm_misaligned  = dm_size && (dm_addr[1:0] != 2'b00);
    assign req_misaligned = pick_dm ? dm_misaligned : if_misaligned;
    assign timed_out      = (tmo_q == TIMEOUT_W - 8'd1);
    assign lane_byte      = mem.mem_rdata[{lat_lane, 3'b000} +: 8];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so block ordering cannot change behaviour.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        if_done       = 1'b0;
        if_rdata      = 32'h0;
        dm_done       = 1'b0;
        dm_rdata      = 32'h0;
        err           = 1'b0;
        owner         = owner_q;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 32'h0;
        mem.mem_be    = 4'h0;
        mem.mem_wdata = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (pick_dm || pick_if)
                    state_d = req_misaligned ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = lat_we;
                mem.mem_addr  = lat_addr;
                mem.mem_be    = lat_be;
                mem.mem_wdata = lat_wdata;
                if (mem.mem_ack || timed_out) state_d = S_RESP;
            end
            S_RESP: begin
                err = err_q;
                if (owner_q == OWN_IF) begin
                    if_done  = 1'b1;
                    if_rdata = rdata_q;
                end else begin
                    dm_done  = 1'b1;
                    dm_rdata = rdata_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant bookkeeping, request latching, timeout count and response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q       <= OWN_NONE;
            starve_q      <= 4'd0;
            tmo_q         <= 8'd0;
            lat_we        <= 1'b0;
            lat_byte_load <= 1'b0;
            lat_lane      <= 2'b00;
            lat_addr      <= 32'h0;
            lat_be        <= 4'h0;
            lat_wdata     <= 32'h0;
            rdata_q       <= 32'h0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tmo_q   <= 8'd0;
                    rdata_q <= 32'h0;
                    if (pick_dm) begin
                        owner_q       <= OWN_DM;
                        if (if_req) starve_q <= starve_q + 4'd1;
                        lat_we        <= dm_we;
                        lat_byte_load <= !dm_size && !dm_we;
                        lat_lane      <= dm_addr[1:0];
                        lat_addr      <= {dm_addr[31:2], 2'b00};
                        lat_be        <= (dm_we && !dm_size) ? (4'b0001 << dm_addr[1:0]) : 4'hF;
                        lat_wdata     <= dm_size ? dm_wdata : {4{dm_wdata[7:0]}};
                        err_q         <= dm_misaligned;
                    end else if (pick_if) begin
                        owner_q       <= OWN_IF;
                        starve_q      <= 4'd0;
                        lat_we        <= 1'b0;
                        lat_byte_load <= 1'b0;
                        lat_lane      <= 2'b00;
                        lat_addr      <= {if_addr[31:2], 2'b00};
                        lat_be        <= 4'hF;
                        lat_wdata     <= 32'h0;
                        err_q         <= if_misaligned;
                    end
                end
                S_ISSUE: begin
                    if (mem.mem_ack) begin
                        rdata_q <= lat_byte_load ? {24'h0, lane_byte} : mem.mem_rdata;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q   <= tmo_q + 8'd1;
                    end
                end
                S_RESP: owner_q <= OWN_NONE;
                default: owner_q <= OWN_NONE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single-requester
// transactions plus hand-written sequences for collision, starvation and
// reset in the middle of a memory cycle.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 16;
    localparam int NEVER      = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic        dm_size;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        err;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter_if mem_bus ();

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_size  (dm_size),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .err      (err),
        .owner    (owner),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic        size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata_in;
        int          ack_wait;   // ISSUE cycles without ack before ack
        logic        exp_issue;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        chk_rd;
    } vec_t;

    function automatic vec_t mk(input logic is_dm, input logic we, input logic size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata_in, input int ack_wait,
                                input logic exp_issue, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic exp_err,
                                input logic [31:0] exp_rdata, input logic chk_rd);
        vec_t v;
        v.is_dm = is_dm; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
        v.rdata_in = rdata_in; v.ack_wait = ack_wait; v.exp_issue = exp_issue;
        v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_err = exp_err;
        v.exp_rdata = exp_rdata; v.chk_rd = chk_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctrl"}, {24'h0, if_done, dm_done, err, owner, mem_bus.mem_req, mem_bus.mem_we, 1'b0}, 32'h0);
        check({tag, " mem_be"}, {28'h0, mem_bus.mem_be}, 32'h0);
        check({tag, " mem_addr"}, mem_bus.mem_addr, 32'h0);
        check({tag, " if_rdata"}, if_rdata, 32'h0);
        check({tag, " dm_rdata"}, dm_rdata, 32'h0);
    endtask

    // Drives one transaction from a single requester, starting on a
    // negedge in IDLE and ending on the negedge of the following IDLE cycle.
    task automatic run_vec(input int idx, input vec_t v);
        int          c = 0;
        int          k = 0;
        int          exp_lat;
        logic        done_seen = 1'b0;
        logic        saw_issue = 1'b0;
        logic [31:0] cap_addr = 32'h0;
        logic [31:0] cap_wdata = 32'h0;
        logic [3:0]  cap_be = 4'h0;
        logic        cap_we = 1'b0;
        logic [31:0] got_rdata = 32'h0;
        logic        got_err = 1'b0;
        logic        got_other = 1'b0;
        logic [1:0]  got_owner = 2'b00;
        logic        got_mreq = 1'b0;
        string       p;
        p = $sformatf("v%0d", idx);
        exp_lat = !v.exp_issue ? 1 : (v.ack_wait >= TIMEOUT ? TIMEOUT + 1 : v.ack_wait + 2);
        mem_bus.mem_rdata = v.rdata_in;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_size = v.size; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        while (!done_seen && c < 40) begin
            step();
            c++;
            if (c == 1) begin
                // Request fields must already be latched; scramble them.
                if_addr = 32'hFFFF_FFF3; dm_addr = 32'hFFFF_FFF1; dm_wdata = 32'h0BAD_F00D;
                dm_we = ~v.we; dm_size = ~v.size;
            end
            if (mem_bus.mem_req) begin
                k++;
                if (!saw_issue) begin
                    saw_issue = 1'b1;
                    cap_addr = mem_bus.mem_addr; cap_wdata = mem_bus.mem_wdata;
                    cap_be = mem_bus.mem_be; cap_we = mem_bus.mem_we;
                end
            end
            mem_bus.mem_ack = mem_bus.mem_req && (k == v.ack_wait + 1);
            if (if_done || dm_done) begin
                done_seen = 1'b1;
                got_rdata = v.is_dm ? dm_rdata : if_rdata;
                got_other = v.is_dm ? if_done : dm_done;
                got_err   = err;
                got_owner = owner;
                got_mreq  = mem_bus.mem_req;
                if_req = 1'b0; dm_req = 1'b0;
            end
        end
        if_req = 1'b0; dm_req = 1'b0; mem_bus.mem_ack = 1'b0;
        check({p, " done seen"}, {31'h0, done_seen}, 32'h1);
        check({p, " latency"}, c, exp_lat);
        check({p, " err"}, {31'h0, got_err}, {31'h0, v.exp_err});
        check({p, " owner"}, {30'h0, got_owner}, v.is_dm ? 32'h2 : 32'h1);
        check({p, " other done"}, {31'h0, got_other}, 32'h0);
        check({p, " mem_req at done"}, {31'h0, got_mreq}, 32'h0);
        check({p, " issued"}, {31'h0, saw_issue}, {31'h0, v.exp_issue});
        if (v.chk_rd) check({p, " rdata"}, got_rdata, v.exp_rdata);
        if (v.exp_issue) begin
            check({p, " mem_addr"}, cap_addr, {v.addr[31:2], 2'b00});
            check({p, " mem_we"}, {31'h0, cap_we}, {31'h0, v.is_dm & v.we});
            check({p, " mem_be"}, {28'h0, cap_be}, {28'h0, v.exp_be});
            if (v.is_dm && v.we) check({p, " mem_wdata"}, cap_wdata, v.exp_wdata);
        end
        step();
        idle_inputs();
    endtask

    vec_t vecs[14];
    int   grants[10];
    int   n_grants;

    initial begin
        // is_dm we size addr wdata rdata_in wait | issue be wdata err rdata chk
        vecs[0]  = mk(0, 0, 1, 32'h0000_0040, 32'h0, 32'h8C01_0004, 0,     1, 4'hF, 32'h0, 0, 32'h8C01_0004, 1);
        vecs[1]  = mk(1, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0,     1, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, 0);
        vecs[2]  = mk(1, 1, 0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0,     1, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0, 0);
        vecs[3]  = mk(1, 0, 0, 32'h0000_0103, 32'h0, 32'hA500_0000, 0,     1, 4'hF, 32'h0, 0, 32'h0000_00A5, 1);
        vecs[4]  = mk(1, 0, 0, 32'h0000_0101, 32'h0, 32'h1122_3344, 1,     1, 4'hF, 32'h0, 0, 32'h0000_0033, 1);
        vecs[5]  = mk(1, 0, 1, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 3,     1, 4'hF, 32'h0, 0, 32'hCAFE_F00D, 1);
        vecs[6]  = mk(1, 1, 0, 32'h0000_0102, 32'h1234_567E, 32'h0, 0,     1, 4'b0100, 32'h7E7E_7E7E, 0, 32'h0, 0);
        vecs[7]  = mk(1, 0, 1, 32'h0000_0102, 32'h0, 32'h7777_7777, 0,     0, 4'hF, 32'h0, 1, 32'h0, 1);
        vecs[8]  = mk(0, 0, 1, 32'h0000_0041, 32'h0, 32'h7777_7777, 0,     0, 4'hF, 32'h0, 1, 32'h0, 1);
        vecs[9]  = mk(1, 0, 1, 32'h0000_0300, 32'h0, 32'h5555_5555, NEVER, 1, 4'hF, 32'h0, 1, 32'h0, 1);
        vecs[10] = mk(0, 0, 1, 32'h0000_0044, 32'h0, 32'h1357_9BDF, 15,    1, 4'hF, 32'h0, 0, 32'h1357_9BDF, 1);
        vecs[11] = mk(1, 0, 0, 32'h0000_0000, 32'h0, 32'hFFFF_FF80, 0,     1, 4'hF, 32'h0, 0, 32'h0000_0080, 1);
        vecs[12] = mk(1, 0, 0, 32'h0000_0003, 32'h0, 32'h9A00_0000, 2,     1, 4'hF, 32'h0, 0, 32'h0000_009A, 1);
        vecs[13] = mk(1, 1, 1, 32'h0000_0106, 32'h0102_0304, 32'h0, 0,     0, 4'hF, 32'h0, 1, 32'h0, 0);

        // Reset state.
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Simultaneous requests: DM store first, IF on the next IDLE.
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b1; dm_size = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        mem_bus.mem_rdata = 32'h8C01_0004;
        step();
        check("collide dm owner", {30'h0, owner}, 32'h2);
        check("collide dm mem_we", {31'h0, mem_bus.mem_we}, 32'h1);
        check("collide dm mem_be", {28'h0, mem_bus.mem_be}, 32'hF);
        check("collide dm wdata", mem_bus.mem_wdata, 32'hDEAD_BEEF);
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        check("collide dm_done", {30'h0, dm_done, if_done}, 32'h2);
        dm_req = 1'b0;
        step();
        check("collide idle owner", {30'h0, owner}, 32'h0);
        step();
        check("collide if owner", {30'h0, owner}, 32'h1);
        check("collide if addr", mem_bus.mem_addr, 32'h40);
        check("collide if mem_we", {31'h0, mem_bus.mem_we}, 32'h0);
        mem_bus.mem_ack = 1'b1;
        step();
        check("collide if_done", {30'h0, dm_done, if_done}, 32'h1);
        check("collide if_rdata", if_rdata, 32'h8C01_0004);
        idle_inputs();
        step();

        // Starvation: both held; expect 4 DM grants then 1 IF, twice.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 1'b1; dm_addr = 32'h10;
        mem_bus.mem_rdata = 32'h2468_ACE0;
        n_grants = 0;
        for (int c = 0; c < 200 && n_grants < 10; c++) begin
            step();
            mem_bus.mem_ack = mem_bus.mem_req;
            if (dm_done) begin grants[n_grants] = 2; n_grants++; end
            else if (if_done) begin grants[n_grants] = 1; n_grants++; end
        end
        idle_inputs();
        check("starve grant count", n_grants, 10);
        for (int i = 0; i < 10 && i < n_grants; i++)
            check($sformatf("starve grant %0d", i), grants[i], (i % 5 == 4) ? 1 : 2);
        step();

        // Reset while a memory cycle is outstanding; a late ack is ignored.
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 1'b1; dm_addr = 32'h20;
        mem_bus.mem_rdata = 32'hFEED_FACE;
        step();
        check("midreset issue", {31'h0, mem_bus.mem_req}, 32'h1);
        rst_n = 1'b0; dm_req = 1'b0;
        step();
        check_all_zero("midreset");
        rst_n = 1'b1; mem_bus.mem_ack = 1'b1;
        step();
        check_all_zero("late ack 1");
        step();
        check_all_zero("late ack 2");
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the pipeline's fetch stage (IF, read-only) and memory stage (DM, read/write, byte or word). It serializes requests through a small state machine, handles byte-lane steering and misalignment, bounds memory latency with a timeout, and prevents fetch starvation. It sits between the IF/MEM stages and the backing memory. The pipeline stalls on `if_req`/`dm_req` until the matching `*_done` pulse.

## Interface
- `STARVE_MAX`, default 4: consecutive DM grants allowed while IF is waiting before IF is forced through. Legal range 1..15.
- `TIMEOUT`, default 16: maximum ISSUE cycles to wait for `mem_ack`. Legal range 1..255.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch read request; held until `if_done`.
- `if_addr` in 32: fetch byte address, word-aligned.
- `if_rdata` out 32: fetched word; valid only while `if_done`=1.
- `if_done` out 1: one-cycle completion pulse.
- `dm_req` in 1: data request; held until `dm_done`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_size` in 1: 1 = word, 0 = byte.
- `dm_addr` in 32: data byte address.
- `dm_wdata` in 32: store data; a byte store uses bits [7:0].
- `dm_rdata` out 32: load data, zero-extended for byte loads; valid while `dm_done`=1.
- `dm_done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `*_done`; 1 = misaligned access or timeout.
- `owner` out 2: 00 idle, 01 IF, 10 DM. Reflects the current transaction.
- `mem_req` out 1: memory request; held until ack or timeout.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables, little-endian lanes (lane 0 = bits [7:0]).
- `mem_wdata` out 32: write data.
- `mem_ack` in 1: memory completion, sampled on the clock edge.
- `mem_rdata` in 32: read word; valid when `mem_ack`=1.

## Operation
- State machine has three states: IDLE, ISSUE, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request pending: arbitrate, then latch the winner's request fields into internal registers.
  - Misaligned request: go directly to RESP with `err`=1. No memory cycle is issued.
  - Aligned request: go to ISSUE.
- ISSUE: `mem_req`=1 and memory outputs driven from the latched fields.
  - `mem_ack`=1: capture `mem_rdata`, go to RESP.
  - `TIMEOUT` ISSUE cycles without ack: go to RESP with `err`=1 and read data 0.
- RESP: pulse the owner's `*_done` for exactly one cycle together with `err` and rdata, then return to IDLE.
- Arbitration:
  - DM has priority over IF. DM is the older instruction, so this avoids deadlock.
  - `starve_cnt` (4-bit) increments on each DM grant made while `if_req`=1.
  - When `starve_cnt` = `STARVE_MAX` and `if_req`=1, IF wins and `starve_cnt` clears.
  - Any IF grant clears `starve_cnt`.
- Alignment rules:
  - IF: `if_addr[1:0]`≠0 is misaligned.
  - DM word access: `dm_addr[1:0]`≠0 is misaligned.
  - DM byte access: never misaligned.
- Byte steering:
  - Byte store: `mem_be = 4'b0001 << addr[1:0]`, and `mem_wdata` = `dm_wdata[7:0]` replicated in all four lanes.
  - Byte load: `dm_rdata = {24'b0, lane addr[1:0] of captured word}`.
  - Word access: `mem_be`=4'hF.
  - Reads drive `mem_we`=0 and `mem_be`=4'hF.
- Request fields are latched in IDLE, so requester inputs are don't-care after the grant.
- A requester whose `req` is still high in the IDLE cycle after its `done` is treated as a new request. Requesters drop `req` on the edge that samples `done`.
- The losing requester keeps its `req` asserted and is served in a later IDLE cycle.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State → IDLE, `starve_cnt`=0.
  - All outputs = 0, including `mem_req`, `*_done`, `err`, `owner`, `mem_be`, rdata.
  - Reset mid-ISSUE drops `mem_req` at that edge and ignores any late `mem_ack`.
- Minimum latency, `req` rising to `done`, is 3 cycles:
  - Cycle 0: IDLE latches the request.
  - Cycle 1: ISSUE with `mem_ack`=1.
  - Cycle 2: RESP, `done`=1.
  - Each extra ack wait cycle adds 1.
- Misaligned access: `done`+`err` in cycle 1, with `mem_req` never asserted.
- Timeout: `done`+`err` appears `TIMEOUT`+1 cycles after the grant edge. `mem_req` deasserts on entry to RESP.
- `owner` is registered. It is nonzero in ISSUE and RESP and returns to 00 in IDLE.
- Back-to-back throughput: one transaction per (ack latency + 2) cycles, since IDLE is mandatory between transactions.
- `mem_ack` arriving outside ISSUE is ignored.

## Test plan
- IF only, `if_addr`=0x40, ack on first ISSUE cycle, `mem_rdata`=0x8C010004 → `if_done` in cycle 2, `if_rdata`=0x8C010004, `err`=0, `owner`=01 during cycles 1–2.
- Simultaneous `if_req` and `dm_req` (store word 0xDEADBEEF @0x100) → DM served first with `mem_we`=1 and `mem_be`=F. IF is served on the next IDLE.
- Byte store 0xA5 @0x103 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5. A following byte load @0x103 with `mem_rdata`=0xA5000000 → `dm_rdata`=0x000000A5.
- `dm_req` held continuously with `if_req` pending, `STARVE_MAX`=4 → 4 DM grants, then an IF grant, then `starve_cnt` back to 0.
- Word load @0x102 → `dm_done`+`err`=1 in cycle 1 with `mem_req` never high. Separately, no ack with `TIMEOUT`=16 → `err`=1, `dm_rdata`=0, `done` 17 cycles after grant.
- `rst_n`=0 mid-ISSUE → next cycle all outputs 0, IDLE. A late `mem_ack` produces no `done`.
